// File: rtl/periph_bus_pkg.sv
// Shared types and defaults for the peripheral bus bridge.
package periph_bus_pkg;

  typedef enum logic [1:0] {
    IDLE,
    STROBE,
    RESP
  } bridge_state_t;

  localparam int unsigned DEFAULT_BUSWIDTH = 32;

endpackage

// File: rtl/periph_addr_decode.sv
// Word-address decoder: one-hot register select gated by enable, plus an in-range flag.
module periph_addr_decode #(
  parameter int unsigned REGS      = 1,
  parameter int unsigned ADDRWIDTH = 1
) (
  input  logic [ADDRWIDTH-1:0] addr,
  input  logic                 en,
  output logic [REGS-1:0]      onehot,
  output logic                 in_range
);

  logic [REGS-1:0] match;

  always_comb begin
    match = '0;
    for (int i = 0; i < REGS; i++) begin
      match[i] = (addr == ADDRWIDTH'(i));
    end
  end

  // Codes with no matching register (REGS not a power of two) fall out as out-of-range.
  assign in_range = |match;
  assign onehot   = match & {REGS{en}};

endmodule

// File: rtl/peripheral_bus_bridge.sv
// Single-beat request/response bridge into a register file with per-register strobes
// and a saturating count of out-of-range accesses.
module peripheral_bus_bridge
  import periph_bus_pkg::*;
#(
  parameter int unsigned BUSWIDTH  = DEFAULT_BUSWIDTH,
  parameter int unsigned REGS      = 1,
  parameter int unsigned ADDRWIDTH = (REGS > 1) ? $clog2(REGS) : 1,
  parameter int unsigned ERRCNTW   = 8
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           req_valid,
  output logic                           req_ready,
  input  logic                           req_write,
  input  logic [ADDRWIDTH-1:0]           req_addr,
  input  logic [BUSWIDTH-1:0]            req_wdata,
  output logic                           rsp_valid,
  input  logic                           rsp_ready,
  output logic [BUSWIDTH-1:0]            rsp_rdata,
  output logic                           rsp_error,
  output logic [BUSWIDTH-1:0]            reg_data_in,
  input  logic [REGS-1:0][BUSWIDTH-1:0]  reg_data_out,
  output logic [REGS-1:0]                reg_write_en,
  output logic [REGS-1:0]                reg_read_en,
  output logic [ERRCNTW-1:0]             err_count
);

  bridge_state_t       state;
  logic                write_q;
  logic                accept;
  logic                in_range;
  logic [REGS-1:0]     sel;
  logic [BUSWIDTH-1:0] read_mux;

  assign req_ready = (state == IDLE);
  assign accept    = req_valid & req_ready;

  periph_addr_decode #(
    .REGS      (REGS),
    .ADDRWIDTH (ADDRWIDTH)
  ) u_decode (
    .addr     (req_addr),
    .en       (accept),
    .onehot   (sel),
    .in_range (in_range)
  );

  // The registered read strobe doubles as the read-data select during STROBE.
  always_comb begin
    read_mux = '0;
    for (int i = 0; i < REGS; i++) begin
      if (reg_read_en[i]) read_mux = read_mux | reg_data_out[i];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      write_q      <= 1'b0;
      rsp_valid    <= 1'b0;
      rsp_rdata    <= '0;
      rsp_error    <= 1'b0;
      reg_data_in  <= '0;
      reg_write_en <= '0;
      reg_read_en  <= '0;
      err_count    <= '0;
    end else begin
      reg_write_en <= '0;
      reg_read_en  <= '0;
      unique case (state)
        IDLE: begin
          if (accept) begin
            write_q     <= req_write;
            reg_data_in <= req_wdata;
            if (in_range) begin
              reg_write_en <= sel & {REGS{req_write}};
              reg_read_en  <= sel & {REGS{~req_write}};
              rsp_error    <= 1'b0;
              state        <= STROBE;
            end else begin
              rsp_rdata <= '0;
              rsp_error <= 1'b1;
              rsp_valid <= 1'b1;
              state     <= RESP;
            end
          end
        end
        STROBE: begin
          rsp_rdata <= write_q ? '0 : read_mux;
          rsp_valid <= 1'b1;
          state     <= RESP;
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            if (rsp_error && (err_count != '1)) err_count <= err_count + 1'b1;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_peripheral_bus_bridge.sv
// Self-checking bench: transaction-level reference model with per-cycle comparison,
// directed literal checks and randomized traffic against a 5-register file.
module tb_peripheral_bus_bridge;

  localparam int unsigned NREG = 5;
  localparam int unsigned AW   = 3;

  logic                       clk = 1'b0;
  logic                       reset = 1'b1;
  logic                       req_valid = 1'b0;
  logic                       req_ready;
  logic                       req_write = 1'b0;
  logic [AW-1:0]              req_addr = '0;
  logic [31:0]                req_wdata = '0;
  logic                       rsp_valid;
  logic                       rsp_ready;
  logic [31:0]                rsp_rdata;
  logic                       rsp_error;
  logic [31:0]                reg_data_in;
  logic [NREG-1:0][31:0]      reg_data_out;
  logic [NREG-1:0]            reg_write_en;
  logic [NREG-1:0]            reg_read_en;
  logic [7:0]                 err_count;

  logic        rand_mode = 1'b0;
  logic        rr_dir = 1'b0;
  logic        rr_rand = 1'b0;
  logic        poke_en = 1'b0;
  logic [2:0]  poke_idx = '0;
  logic [31:0] poke_val = '0;
  logic [31:0] env [NREG] = '{default: 32'h0};
  logic [31:0] mdl [NREG] = '{default: 32'h0};

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  assign rsp_ready = rand_mode ? rr_rand : rr_dir;

  peripheral_bus_bridge #(
    .BUSWIDTH  (32),
    .REGS      (NREG),
    .ADDRWIDTH (AW),
    .ERRCNTW   (8)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_write    (req_write),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .rsp_valid    (rsp_valid),
    .rsp_ready    (rsp_ready),
    .rsp_rdata    (rsp_rdata),
    .rsp_error    (rsp_error),
    .reg_data_in  (reg_data_in),
    .reg_data_out (reg_data_out),
    .reg_write_en (reg_write_en),
    .reg_read_en  (reg_read_en),
    .err_count    (err_count)
  );

  // External register file behind the bridge.
  always @(posedge clk) begin
    for (int i = 0; i < NREG; i++) begin
      if (reg_write_en[i]) env[i] <= reg_data_in;
    end
    if (poke_en) env[poke_idx] <= poke_val;
    rr_rand <= ($urandom_range(0, 2) != 0);
  end

  always_comb begin
    for (int i = 0; i < NREG; i++) reg_data_out[i] = env[i];
  end

  always @(posedge clk) begin
    if (!reset) begin
      assert ((reg_write_en & reg_read_en) == '0 && $countones(reg_write_en | reg_read_en) <= 1);
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: one transaction in flight, timed by cycles since its accept.
  logic        primed = 1'b0;
  logic        busy = 1'b0;
  int          age = 0;
  logic        t_write = 1'b0;
  logic        t_err = 1'b0;
  logic [2:0]  t_addr = '0;
  logic [31:0] t_rdata = '0;
  logic [31:0] exp_din = '0;
  logic [7:0]  err_m = '0;
  logic [4:0]  exp_we;
  logic [4:0]  exp_re;
  logic        exp_v;

  always @(negedge clk) begin
    exp_v  = busy && (age >= (t_err ? 1 : 2));
    exp_we = '0;
    exp_re = '0;
    if (busy && !t_err && age == 1) begin
      if (t_write) exp_we = 5'b00001 << t_addr;
      else         exp_re = 5'b00001 << t_addr;
    end
    if (primed) begin
      check("req_ready", {31'b0, req_ready}, {31'b0, !busy});
      check("rsp_valid", {31'b0, rsp_valid}, {31'b0, exp_v});
      check("write_en", {27'b0, reg_write_en}, {27'b0, exp_we});
      check("read_en", {27'b0, reg_read_en}, {27'b0, exp_re});
      check("reg_data_in", reg_data_in, exp_din);
      check("err_count", {24'b0, err_count}, {24'b0, err_m});
      if (exp_v) begin
        check("rsp_rdata", rsp_rdata, t_rdata);
        check("rsp_error", {31'b0, rsp_error}, {31'b0, t_err});
      end
    end
    if (reset) begin
      busy    = 1'b0;
      exp_din = '0;
      err_m   = '0;
      primed  = 1'b1;
    end else if (primed) begin
      if (busy) begin
        if (exp_v && rsp_ready) begin
          busy = 1'b0;
          if (t_err && err_m != 8'hFF) err_m = err_m + 8'd1;
        end else begin
          age++;
        end
      end else if (req_valid) begin
        busy    = 1'b1;
        age     = 1;
        t_write = req_write;
        t_addr  = req_addr;
        t_err   = (req_addr >= NREG);
        exp_din = req_wdata;
        t_rdata = (t_err || t_write) ? 32'h0 : mdl[req_addr];
        if (!t_err && t_write) mdl[req_addr] = req_wdata;
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Present a request and return just after the edge that accepts it.
  task automatic issue(input logic w, input logic [2:0] a, input logic [31:0] d);
    int k;
    req_valid = 1'b1;
    req_write = w;
    req_addr  = a;
    req_wdata = d;
    k = 0;
    while (!req_ready && k < 100) begin
      tick(1);
      k++;
    end
    if (!req_ready) check("accept_timeout", 32'd0, 32'd1);
    tick(1);
    req_valid = 1'b0;
  endtask

  task automatic complete();
    int k;
    rr_dir = 1'b1;
    k = 0;
    while (!rsp_valid && k < 20) begin
      tick(1);
      k++;
    end
    if (!rsp_valid) check("rsp_timeout", 32'd0, 32'd1);
    tick(1);
    rr_dir = 1'b0;
  endtask

  initial begin
    tick(3);
    reset = 1'b0;
    check("reset_req_ready", {31'b0, req_ready}, 32'd1);
    check("reset_rsp_valid", {31'b0, rsp_valid}, 32'd0);
    check("reset_err_count", {24'b0, err_count}, 32'd0);

    // Write with timing of strobe and response.
    issue(1'b1, 3'd0, 32'hDEADBEEF);
    check("wr_strobe", {27'b0, reg_write_en}, 32'h01);
    check("wr_data_in", reg_data_in, 32'hDEADBEEF);
    check("wr_valid_early", {31'b0, rsp_valid}, 32'd0);
    tick(1);
    check("wr_strobe_off", {27'b0, reg_write_en}, 32'h00);
    check("wr_valid", {31'b0, rsp_valid}, 32'd1);
    check("wr_rdata", rsp_rdata, 32'h0);
    check("wr_error", {31'b0, rsp_error}, 32'd0);
    complete();

    // Read captures value at strobe; later register change must not leak through.
    issue(1'b1, 3'd3, 32'h12345678);
    complete();
    issue(1'b0, 3'd3, 32'h0);
    check("rd_strobe", {27'b0, reg_read_en}, 32'h08);
    poke_en  = 1'b1;
    poke_idx = 3'd3;
    poke_val = 32'hCAFEF00D;
    tick(1);
    poke_en = 1'b0;
    check("rd_rdata", rsp_rdata, 32'h12345678);

    // Backpressure: pending request waits until after the response handshake.
    req_valid = 1'b1;
    req_write = 1'b1;
    req_addr  = 3'd1;
    req_wdata = 32'h0BADCAFE;
    for (int i = 0; i < 10; i++) begin
      tick(1);
      check("hold_valid", {31'b0, rsp_valid}, 32'd1);
      check("hold_ready", {31'b0, req_ready}, 32'd0);
      check("hold_rdata", rsp_rdata, 32'h12345678);
    end
    rr_dir = 1'b1;
    tick(1);
    rr_dir = 1'b0;
    check("post_hs_ready", {31'b0, req_ready}, 32'd1);
    tick(1);
    req_valid = 1'b0;
    check("late_accept", {27'b0, reg_write_en}, 32'h02);
    complete();
    issue(1'b1, 3'd3, 32'h0);
    complete();

    // Out-of-range accesses and counter saturation.
    issue(1'b0, 3'd5, 32'h0);
    check("err_no_wr", {27'b0, reg_write_en}, 32'h0);
    check("err_no_rd", {27'b0, reg_read_en}, 32'h0);
    check("err_valid", {31'b0, rsp_valid}, 32'd1);
    check("err_flag", {31'b0, rsp_error}, 32'd1);
    check("err_rdata", rsp_rdata, 32'h0);
    complete();
    check("err_count_1", {24'b0, err_count}, 32'd1);
    for (int i = 0; i < 260; i++) begin
      issue(i[0], 3'd5 + 3'(i % 3), 32'(i));
      complete();
    end
    check("err_count_sat", {24'b0, err_count}, 32'hFF);

    // Reset during STROBE and during RESP.
    issue(1'b1, 3'd2, 32'h55);
    check("rst_strobe_pre", {27'b0, reg_write_en}, 32'h04);
    reset = 1'b1;
    tick(1);
    reset = 1'b0;
    check("rst1_strobes", {27'b0, reg_write_en | reg_read_en}, 32'h0);
    check("rst1_valid", {31'b0, rsp_valid}, 32'd0);
    check("rst1_err_count", {24'b0, err_count}, 32'd0);
    check("rst1_ready", {31'b0, req_ready}, 32'd1);
    check("rst1_data_in", reg_data_in, 32'h0);
    issue(1'b0, 3'd2, 32'h0);
    tick(1);
    check("rst2_pre_valid", {31'b0, rsp_valid}, 32'd1);
    check("rst2_pre_rdata", rsp_rdata, 32'h55);
    reset = 1'b1;
    tick(1);
    reset = 1'b0;
    check("rst2_valid", {31'b0, rsp_valid}, 32'd0);
    check("rst2_ready", {31'b0, req_ready}, 32'd1);
    check("rst2_rdata", rsp_rdata, 32'h0);

    // Randomized traffic with random response backpressure.
    rand_mode = 1'b1;
    for (int n = 0; n < 1000; n++) begin
      if ($urandom_range(0, 3) == 0) tick(1);
      issue(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), $urandom);
    end
    rand_mode = 1'b0;
    rr_dir    = 1'b1;
    tick(10);
    check("drain_idle", {31'b0, req_ready}, 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
